// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: FSM state type and default parameters shared by interval_timer
// Contents: state_t (IDLE/RUN/HOLD), DEF_TICK_DIV, DEF_CNT_W, DEF_NSEL
package interval_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam int DEF_TICK_DIV = 50000000;
  localparam int DEF_CNT_W = 6;
  localparam int DEF_NSEL = 4;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into one tick every TICK_DIV enabled cycles
// Ports: clk, reset (sync, active-high), clear (restart count), enable (advance), tick (count at TICK_DIV-1)
module tick_prescaler
  import interval_timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == LAST;
  always_ff @(posedge clk)
    if (reset || clear) r_cnt <= '0;
    else if (enable) r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/interval_timer.sv
// interval_timer: table-driven one-shot/periodic countdown timer with hold and abort
// Ports: clk, reset (sync, active-high); durations (NSEL x CNT_W table), sel, start, hold, abort, periodic;
//        expired/err (one-cycle pulses), busy (state != IDLE), remaining (ticks left)
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W = DEF_CNT_W,
  parameter int NSEL = DEF_NSEL,
  localparam int SEL_W = NSEL > 1 ? $clog2(NSEL) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSEL*CNT_W-1:0] durations,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  abort,
  input  logic                  periodic,
  output logic                  expired,
  output logic                  err,
  output logic                  busy,
  output logic [CNT_W-1:0]      remaining
);
  state_t r_state;
  logic [CNT_W-1:0] r_rem, r_d, w_dur;
  logic r_expired, r_err, w_sel_ok, w_tick;
  assign w_sel_ok = 32'(sel) < NSEL;
  always_comb begin
    w_dur = '0;
    for (int i = 0; i < NSEL; i++) if (32'(sel) == i) w_dur = durations[i*CNT_W +: CNT_W];
  end
  // An out-of-range start freezes the whole edge, so the prescaler must not advance on any start
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk),
    .reset(reset),
    .clear(start && w_sel_ok),
    .enable(busy && !hold && !start && !abort),
    .tick(w_tick)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_rem <= '0;
      r_d <= '0;
      r_expired <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      r_err <= 1'b0;
      if (start) begin
        if (!w_sel_ok) r_err <= 1'b1;
        else if (w_dur == '0) begin
          r_expired <= 1'b1;
          r_rem <= '0;
          r_state <= IDLE;
        end else begin
          r_d <= w_dur;
          r_rem <= w_dur;
          r_state <= RUN;
        end
      end else if (r_state != IDLE) begin
        if (abort) begin
          r_state <= IDLE;
          r_rem <= '0;
        end else if (hold) r_state <= HOLD;
        else begin
          r_state <= RUN;
          if (w_tick) begin
            if (r_rem == CNT_W'(1)) begin
              r_expired <= 1'b1;
              r_rem <= periodic ? r_d : '0;
              r_state <= periodic ? RUN : IDLE;
            end else r_rem <= r_rem - 1'b1;
          end
        end
      end
    end
  assign expired = r_expired;
  assign err = r_err;
  assign busy = r_state != IDLE;
  assign remaining = r_rem;
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scoreboard bench for interval_timer at TICK_DIV=4, CNT_W=6, NSEL=4 (and NSEL=3)
module tb_interval_timer;
  localparam int CW = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4*CW-1:0] durations = {6'd3, 6'd5, 6'd2, 6'd0};
  logic [3*CW-1:0] durations3 = {6'd5, 6'd2, 6'd0};
  logic [1:0] sel = 2'd0, sel3 = 2'd0;
  logic start = 1'b0, start3 = 1'b0, hold = 1'b0, abort = 1'b0, periodic = 1'b0;
  logic expired, err, busy, expired3, err3, busy3;
  logic [CW-1:0] remaining, remaining3;
  logic [8:0] exp_q[$];
  logic [8:0] obs, want;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  interval_timer #(.TICK_DIV(4), .CNT_W(CW), .NSEL(4)) dut (
    .clk(clk), .reset(reset), .durations(durations), .sel(sel), .start(start),
    .hold(hold), .abort(abort), .periodic(periodic),
    .expired(expired), .err(err), .busy(busy), .remaining(remaining)
  );
  interval_timer #(.TICK_DIV(4), .CNT_W(CW), .NSEL(3)) dut3 (
    .clk(clk), .reset(reset), .durations(durations3), .sel(sel3), .start(start3),
    .hold(1'b0), .abort(1'b0), .periodic(1'b0),
    .expired(expired3), .err(err3), .busy(busy3), .remaining(remaining3)
  );
  function automatic logic [8:0] pk(logic e, logic r, logic b, int rem);
    return {e, r, b, 6'(rem)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pk(0, 0, 0, 0));
      exp_q.push_back(pk(0, 0, 0, 0));
    end
    for (int k = 0; k < 2; k++) begin
      step();
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL reset k=%0d got %b want %b", k, obs, want); else passed++;
      obs = {expired3, err3, busy3, remaining3};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL reset3 k=%0d got %b want %b", k, obs, want); else passed++;
    end
    reset = 1'b0;
    step();
  endtask
  task automatic test_oneshot();
    for (int k = 0; k <= 10; k++) exp_q.push_back(pk(k == 8, 0, k < 8, k < 8 ? 2 - k / 4 : 0));
    sel = 2'd1;
    start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      start = 1'b0;
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL oneshot k=%0d got %b want %b", k, obs, want); else passed++;
    end
  endtask
  task automatic test_periodic();
    for (int k = 0; k < 30; k++)
      exp_q.push_back(pk(k % 4 == 0 && k / 4 > 0 && (k / 4) % 3 == 0, 0, 1, 3 - (k / 4) % 3));
    exp_q.push_back(pk(0, 0, 0, 0));
    sel = 2'd3;
    periodic = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      start = 1'b0;
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL periodic k=%0d got %b want %b", k, obs, want); else passed++;
    end
    periodic = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    obs = {expired, err, busy, remaining};
    want = exp_q.pop_front();
    total++;
    if (obs !== want) $display("FAIL periodic_abort got %b want %b", obs, want); else passed++;
  endtask
  task automatic test_hold();
    int a = 0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0 && !(k >= 5 && k <= 11)) a++;
      exp_q.push_back(pk(a == 20, 0, a < 20, a < 20 ? 5 - a / 4 : 0));
    end
    sel = 2'd2;
    start = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      step();
      start = 1'b0;
      hold = k + 1 >= 5 && k + 1 <= 11;
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL hold k=%0d got %b want %b", k, obs, want); else passed++;
    end
  endtask
  task automatic test_zero_and_err();
    int a = 0;
    exp_q.push_back(pk(1, 0, 0, 0));
    exp_q.push_back(pk(0, 0, 0, 0));
    sel = 2'd0;
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      start = 1'b0;
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL zero k=%0d got %b want %b", k, obs, want); else passed++;
    end
    for (int k = 0; k <= 11; k++) begin
      if (k > 0 && k != 2) a++;
      exp_q.push_back(pk(a == 8, k == 2, a < 8, a < 8 ? 2 - a / 4 : 0));
    end
    sel3 = 2'd1;
    start3 = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step();
      start3 = k + 1 == 2;
      sel3 = k + 1 == 2 ? 2'd3 : 2'd1;
      obs = {expired3, err3, busy3, remaining3};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL err k=%0d got %b want %b", k, obs, want); else passed++;
    end
  endtask
  task automatic test_abort();
    for (int k = 0; k <= 24; k++) exp_q.push_back(k < 6 ? pk(0, 0, 1, 5 - k / 4) : pk(0, 0, 0, 0));
    sel = 2'd2;
    start = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      step();
      start = 1'b0;
      abort = k + 1 == 6 || k + 1 == 10;
      hold = k + 1 >= 12 && k + 1 <= 14;
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL abort k=%0d got %b want %b", k, obs, want); else passed++;
    end
  endtask
  task automatic test_restart_and_reset();
    for (int k = 0; k <= 19; k++)
      exp_q.push_back(k < 6 ? pk(0, 0, 1, 2 - k / 4) :
                      pk(k - 6 == 12, 0, k - 6 < 12, k - 6 < 12 ? 3 - (k - 6) / 4 : 0));
    sel = 2'd1;
    start = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      step();
      start = k + 1 == 6;
      sel = k + 1 == 6 ? 2'd3 : 2'd1;
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL restart k=%0d got %b want %b", k, obs, want); else passed++;
    end
    for (int k = 0; k <= 10; k++) exp_q.push_back(k < 8 ? pk(0, 0, 1, 2 - k / 4) : pk(0, 0, 0, 0));
    sel = 2'd1;
    start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      start = 1'b0;
      reset = k + 1 == 8;
      obs = {expired, err, busy, remaining};
      want = exp_q.pop_front();
      total++;
      if (obs !== want) $display("FAIL reset_mid k=%0d got %b want %b", k, obs, want); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_hold();
    test_zero_and_err();
    test_abort();
    test_restart_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving the clk cycles per timer tick (legal range >= 1).
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the width of each duration and of the remaining count.
REQ-003 The block SHALL have parameter NSEL, default 4, giving the number of duration table entries; SEL_W = max(1, clog2(NSEL)).
REQ-004 The block SHALL have port clk, input, 1, clock; reset reset, synchronous, active-high; clock clk.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port durations, input, NSEL*CNT_W, duration table; entry i is at [i*CNT_W +: CNT_W].
REQ-007 The block SHALL have port sel, input, SEL_W, table index used at start.
REQ-008 The block SHALL have ports start, hold, abort and periodic, each an input of 1 bit: load/restart, freeze, cancel, and auto-reload enable.
REQ-009 The block SHALL have outputs expired (1, one-cycle pulse), err (1, one-cycle pulse), busy (1) and remaining (CNT_W, ticks left).

Function
REQ-010 The FSM SHALL have states IDLE, RUN and HOLD; busy SHALL be 1 exactly when the state is not IDLE.
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 and assert tick combinationally while at TICK_DIV-1, advancing only on edges where state is RUN/HOLD and hold=0.
REQ-012 Start SHALL be evaluated in any state, with priority start > abort > hold > tick.
REQ-013 Start with sel<NSEL and durations[sel]!=0 SHALL latch D=durations[sel] and sel, set remaining=D, clear the prescaler and enter RUN.
REQ-014 Start with durations[sel]==0 SHALL pulse expired on the next cycle, set remaining=0 and enter IDLE.
REQ-015 Start with sel>=NSEL SHALL pulse err for one cycle, leave the state, remaining and prescaler unchanged, and not pulse expired.
REQ-016 In RUN/HOLD with hold=0, tick SHALL decrement remaining by 1.
REQ-017 On a tick with remaining==1, expired SHALL pulse for one cycle.
REQ-018 On that expiry tick with periodic=0, remaining SHALL become 0 and the state SHALL become IDLE.
REQ-019 On that expiry tick with periodic=1, remaining SHALL reload to the latched D and the state SHALL remain RUN, with no gap cycle.
REQ-020 The latency SHALL be exactly D*TICK_DIV clk edges from the start edge to the edge raising expired, when hold is never asserted.
REQ-021 An edge with hold=1 in RUN/HOLD SHALL enter or stay in HOLD and freeze the prescaler and remaining; hold=0 in HOLD SHALL return to RUN.
REQ-022 Abort in RUN/HOLD SHALL enter IDLE with remaining=0 and no expired pulse; abort in IDLE SHALL be ignored.
REQ-023 Hold, periodic-independent ticks and abort in IDLE SHALL have no effect, and remaining SHALL stay constant in IDLE.
REQ-024 Changes to durations or sel after the start edge SHALL NOT affect the current run or its periodic reloads.
REQ-025 Arithmetic SHALL be unsigned, and remaining SHALL never underflow below 0.
REQ-026 TICK_DIV=1 SHALL produce a tick on every enabled cycle.

Reset
REQ-027 Reset SHALL force state=IDLE, remaining=0, prescaler=0, latched D=0, latched sel=0, and expired=err=busy=0 on the next edge.
REQ-028 Reset SHALL override start, abort and hold, and SHALL suppress any expiry due on that edge, including reset mid-run.

Structure
REQ-029 Package interval_timer_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-030 The prescaler SHALL be a sub-module tick_prescaler with ports clk, reset, clear, enable and tick, parametrised by TICK_DIV.

Verification (TICK_DIV=4, CNT_W=6, NSEL=4)
REQ-031 Durations={0,2,5,3}, start with sel=1, periodic=0 -> expired at edge 8, busy falls at edge 8, remaining steps 2,1,0.
REQ-032 Sel=3, periodic=1, run for 30 edges -> expired at edges 12 and 24, busy stays 1, remaining reloads to 3.
REQ-033 Sel=2, hold asserted for 7 cycles starting at edge 5 -> expired moves from edge 20 to edge 27.
REQ-034 Sel=0 -> expired pulses 1 cycle after start and busy stays 0; with NSEL=3 and sel=3 -> err pulses and the state is unchanged.
REQ-035 Abort at edge 6 of a sel=2 run -> IDLE, remaining=0, and no expired pulse ever appears.
REQ-036 Start while RUN at remaining=1 -> restart with the new D and no expired pulse; reset at the expiry edge -> no expired pulse.
